// File: rtl/nukv_value_segmenter_mc.sv
// Multi-channel value segmenter: round-robin packet arbitration over the
// value streams, length-header decode, truncation with drain, and a
// 2-entry skid buffer in front of the output.
`timescale 1ns/1ps
module nukv_value_segmenter_mc #(
  parameter int DATA_WIDTH = 512,
  parameter int N_CHANNELS = 4,
  parameter int CHAN_W     = 2,
  parameter int LEN_LSB    = 0,
  parameter int LEN_UNIT   = 8,
  parameter int MAX_BEATS  = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [N_CHANNELS-1:0]          in_valid,
  output logic [N_CHANNELS-1:0]          in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [CHAN_W-1:0]              out_chan,
  output logic                           out_err,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int LU_SH = $clog2(LEN_UNIT);
  localparam int BB_SH = $clog2(DATA_WIDTH/8);
  localparam int BW    = 17 + LU_SH;

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  typedef struct packed {
    logic                  err;
    logic                  last;
    logic [CHAN_W-1:0]     chan;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t              state, state_n;
  logic                active;
  logic [CHAN_W-1:0]   rr_ptr, grant, win, win_hi, win_lo;
  logic                found_hi, found_lo;
  logic [DATA_WIDTH-1:0] win_data, sel_data;
  logic                sel_valid;
  logic [15:0]         len;
  logic [BW-1:0]       bytes, beats_raw, beats, emit, drain, left, rem;
  logic                trunc, trunc_r;
  logic                hdr_fire, beat_fire, drain_fire;
  logic                ready_en;
  logic [CHAN_W-1:0]   ready_ch;
  logic                push, pop;
  entry_t              push_entry;
  entry_t              mem [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          cnt;

  // Round-robin winner search and per-channel muxing of the winner/granted streams
  always_comb begin
    win_hi    = '0;
    win_lo    = '0;
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    win_data  = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int c = N_CHANNELS-1; c >= 0; c--) begin
      if (in_valid[c]) begin
        win_lo   = CHAN_W'(c);
        found_lo = 1'b1;
        if (c >= int'(rr_ptr)) begin
          win_hi   = CHAN_W'(c);
          found_hi = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (win == CHAN_W'(c)) win_data = in_data[c*DATA_WIDTH +: DATA_WIDTH];
      if (grant == CHAN_W'(c)) begin
        sel_valid = in_valid[c];
        sel_data  = in_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Header decode: bytes and beat count by shifts only, clamped to MAX_BEATS
  always_comb begin
    len       = win_data[LEN_LSB +: 16];
    bytes     = BW'(len) << LU_SH;
    beats_raw = (bytes + BW'(DATA_WIDTH/8 - 1)) >> BB_SH;
    beats     = (len == 16'd0) ? BW'(1) : beats_raw;
    trunc     = beats > BW'(MAX_BEATS);
    emit      = trunc ? BW'(MAX_BEATS) : beats;
    drain     = beats - emit;
  end

  // Next-state, input acceptance and skid push selection
  always_comb begin
    state_n    = state;
    hdr_fire   = 1'b0;
    beat_fire  = 1'b0;
    drain_fire = 1'b0;
    ready_en   = 1'b0;
    ready_ch   = grant;
    push       = 1'b0;
    push_entry = '{err: 1'b0, last: 1'b0, chan: grant, data: sel_data};
    case (state)
      IDLE: begin
        if (active && found_lo && cnt != 2'd2) begin
          ready_en   = 1'b1;
          ready_ch   = win;
          hdr_fire   = 1'b1;
          push       = 1'b1;
          push_entry = '{err: (emit == BW'(1)) && trunc, last: emit == BW'(1),
                         chan: win, data: win_data};
          if (emit > BW'(1))        state_n = PASS;
          else if (drain != '0)     state_n = DRAIN;
        end
      end
      PASS: begin
        ready_en = (cnt != 2'd2);
        if (sel_valid && ready_en) begin
          beat_fire  = 1'b1;
          push       = 1'b1;
          push_entry = '{err: (left == BW'(1)) && trunc_r, last: left == BW'(1),
                         chan: grant, data: sel_data};
          if (left == BW'(1)) state_n = (rem != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        ready_en = 1'b1;
        if (sel_valid) begin
          drain_fire = 1'b1;
          if (rem == BW'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // One-hot ready towards the selected channel only
  always_comb begin
    in_ready = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      in_ready[c] = ready_en && (ready_ch == CHAN_W'(c));
    end
  end

  // Packet context: state, grant, round-robin pointer and beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      active  <= 1'b0;
      grant   <= '0;
      rr_ptr  <= '0;
      left    <= '0;
      rem     <= '0;
      trunc_r <= 1'b0;
    end else begin
      active <= 1'b1;
      state  <= state_n;
      if (hdr_fire) begin
        grant   <= win;
        rr_ptr  <= (int'(win) == N_CHANNELS-1) ? '0 : win + 1'b1;
        left    <= emit - BW'(1);
        rem     <= drain;
        trunc_r <= trunc;
      end
      if (beat_fire)  left <= left - BW'(1);
      if (drain_fire) rem  <= rem - BW'(1);
    end
  end

  assign pop = out_valid && out_ready;

  // Two-entry skid FIFO feeding the output port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr].data;
  assign out_last  = mem[rd_ptr].last;
  assign out_err   = mem[rd_ptr].err;
  assign out_chan  = mem[rd_ptr].chan;
  assign busy      = (state != IDLE) || (cnt != 2'd0);

endmodule

// File: tb/tb_nukv_value_segmenter_mc.sv
// Self-checking bench for nukv_value_segmenter_mc: vector table of single
// packets, plus hand sequences for stalls, reset, round robin and a
// single-channel narrow configuration.
`timescale 1ns/1ps
module tb_nukv_value_segmenter_mc;

  typedef struct { logic [511:0] data; bit out; bit last; bit err; } src_t;
  typedef struct { logic [511:0] data; bit last; bit err; logic [1:0] chan; int hs_cyc; } exp_t;
  typedef struct { int chan; int len; int n_in; int n_out; bit err; } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2047:0] in_data;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [511:0]  out_data;
  logic          out_valid, out_last, out_err, out_ready, busy;
  logic [1:0]    out_chan;

  logic [127:0]  in1_data;
  logic [0:0]    in1_valid, in1_ready;
  logic [127:0]  out1_data;
  logic          out1_valid, out1_last, out1_err, out1_ready, busy1;
  logic [0:0]    out1_chan;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;
  int in_stall = 0;

  src_t src_q[4][$];
  exp_t exp_q[$];
  int   last_chan_q[$];

  int out_beats, in_beats, last_cnt, err_cnt, first_out_cyc, last_out_cyc;
  bit full_seen;
  bit held;
  logic [511:0] held_data;
  logic held_last, held_err;
  logic [1:0] held_chan;
  bit prev_last_hs = 1'b1;
  logic [1:0] prev_chan;

  always #5 clk = ~clk;

  nukv_value_segmenter_mc #(.DATA_WIDTH(512), .N_CHANNELS(4), .CHAN_W(2), .LEN_LSB(0),
                            .LEN_UNIT(8), .MAX_BEATS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_chan(out_chan),
    .out_err(out_err), .out_ready(out_ready), .busy(busy));

  nukv_value_segmenter_mc #(.DATA_WIDTH(128), .N_CHANNELS(1), .CHAN_W(1), .LEN_LSB(16),
                            .LEN_UNIT(1), .MAX_BEATS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in1_data), .in_valid(in1_valid), .in_ready(in1_ready),
    .out_data(out1_data), .out_valid(out1_valid), .out_last(out1_last), .out_chan(out1_chan),
    .out_err(out1_err), .out_ready(out1_ready), .busy(busy1));

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearStats();
    out_beats = 0; in_beats = 0; last_cnt = 0; err_cnt = 0;
    first_out_cyc = 0; last_out_cyc = 0; full_seen = 1'b0;
    last_chan_q.delete();
  endtask

  // Build one packet for channel c; the model decides which beats reach the output
  task automatic applyStimulus(input int c, input int len);
    int beats, emit;
    src_t s;
    beats = (len == 0) ? 1 : (len * 8 + 63) / 64;
    emit  = (beats > 16) ? 16 : beats;
    for (int i = 0; i < beats; i++) begin
      for (int w = 0; w < 16; w++) s.data[w*32 +: 32] = $urandom();
      if (i == 0) s.data[15:0] = len[15:0];
      s.out  = (i < emit);
      s.last = (i == emit - 1);
      s.err  = s.last && (beats > 16);
      src_q[c].push_back(s);
    end
  endtask

  // Output-side checks: occupancy rule, hold stability, scoreboard compare
  task automatic monitorOutputs();
    exp_t e;
    if (exp_q.size() == 2) begin
      full_seen = 1'b1;
      for (int c = 0; c < 4; c++)
        if (in_valid[c] && src_q[c].size() > 0 && src_q[c][0].out)
          checkOutput("ready_when_full", in_ready[c], 0);
    end
    checkOutput("ready_onehot", $countones(in_ready) <= 1, 1);
    if (held) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_data", out_data, held_data);
      checkOutput("hold_last", out_last, held_last);
      checkOutput("hold_err", out_err, held_err);
      checkOutput("hold_chan", out_chan, held_chan);
    end
    held = out_valid && !out_ready;
    held_data = out_data; held_last = out_last; held_err = out_err; held_chan = out_chan;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_last", out_last, e.last);
        checkOutput("out_err", out_err, e.err);
        checkOutput("out_chan", out_chan, e.chan);
        if (ready_mode == 0) checkOutput("latency", cyc - e.hs_cyc, 1);
        if (!prev_last_hs) checkOutput("no_interleave", out_chan, prev_chan);
        prev_last_hs = out_last;
        prev_chan = out_chan;
        if (out_beats == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_beats++;
        if (out_last) begin
          last_cnt++;
          last_chan_q.push_back(int'(out_chan));
        end
        if (out_err) err_cnt++;
      end
    end
  endtask

  // Input-side handshakes retire source beats and queue their expected outputs
  task automatic acceptInputs();
    src_t s;
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (in_valid[c] && in_ready[c]) begin
        s = src_q[c].pop_front();
        in_beats++;
        if (s.out) begin
          e.data = s.data; e.last = s.last; e.err = s.err;
          e.chan = 2'(c); e.hs_cyc = cyc;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Driver/monitor loop for the 4-channel instance, one pass per cycle
  initial begin : driver
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_valid = '0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (src_q[c].size() > 0 && int'($urandom_range(0, 99)) >= in_stall) begin
            in_valid[c] = 1'b1;
            in_data[c*512 +: 512] = src_q[c][0].data;
          end else begin
            in_valid[c] = 1'b0;
          end
        end
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc % 2 == 0);
          default: out_ready = $urandom_range(0, 1) == 1;
        endcase
        #1;
        monitorOutputs();
        acceptInputs();
        cyc++;
      end
    end
  end

  task automatic waitDone(input int budget);
    int k = 0;
    while (k < budget && !(src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                          src_q[3].size() == 0 && exp_q.size() == 0 && !busy)) begin
      @(negedge clk); #3;
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got busy=%0b pending=%0d expected idle", busy, exp_q.size());
    end
  endtask

  initial begin : watchdog
    #950000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[8];
  int rr_exp[6];
  logic [127:0] d1[3];
  int guard;

  initial begin : main
    vecs[0] = '{0, 8, 1, 1, 0};
    vecs[1] = '{0, 0, 1, 1, 0};
    vecs[2] = '{0, 9, 2, 2, 0};
    vecs[3] = '{0, 128, 16, 16, 0};
    vecs[4] = '{2, 200, 25, 16, 1};
    vecs[5] = '{1, 127, 16, 16, 0};
    vecs[6] = '{3, 136, 17, 16, 1};
    vecs[7] = '{1, 65535, 8192, 16, 1};
    rr_exp = '{0, 3, 0, 3, 0, 3};

    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    in1_valid = '0; in1_data = '0; out1_ready = 1'b1;
    clearStats();
    repeat (3) @(negedge clk);
    #2 in_valid = 4'b0110;
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_err", out_err, 0);
    checkOutput("rst_out_chan", out_chan, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst1_out_valid", out1_valid, 0);
    in_valid = '0;
    @(negedge clk); #2 rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      clearStats();
      applyStimulus(vecs[v].chan, vecs[v].len);
      waitDone(vecs[v].n_in + 60);
      $display("[TB] vector %0d: ch%0d len=%0d out=%0d in=%0d", v, vecs[v].chan, vecs[v].len, out_beats, in_beats);
      checkOutput("vec_out_beats", out_beats, vecs[v].n_out);
      checkOutput("vec_in_beats", in_beats, vecs[v].n_in);
      checkOutput("vec_last_cnt", last_cnt, 1);
      checkOutput("vec_err_cnt", err_cnt, vecs[v].err);
      checkOutput("vec_busy_end", busy, 0);
    end

    clearStats();
    ready_mode = 1;
    applyStimulus(1, 40);
    waitDone(100);
    checkOutput("toggle_out_beats", out_beats, 5);
    checkOutput("toggle_full_seen", full_seen, 1);
    ready_mode = 2; in_stall = 30;
    clearStats();
    applyStimulus(1, 40);
    applyStimulus(1, 40);
    waitDone(300);
    checkOutput("random_out_beats", out_beats, 10);
    checkOutput("random_last_cnt", last_cnt, 2);
    ready_mode = 0; in_stall = 0;

    clearStats();
    applyStimulus(1, 80);
    guard = 0;
    while (in_beats < 3 && guard < 50) begin @(negedge clk); #3; guard++; end
    checkOutput("rst_mid_reached", in_beats >= 3, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", out_valid, 0);
    checkOutput("rst_mid_in_ready", in_ready, 0);
    checkOutput("rst_mid_busy", busy, 0);
    for (int c = 0; c < 4; c++) src_q[c].delete();
    exp_q.delete();
    held = 1'b0; prev_last_hs = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    clearStats();
    applyStimulus(3, 9);
    applyStimulus(0, 9);
    waitDone(60);
    checkOutput("post_rst_pkts", last_chan_q.size(), 2);
    if (last_chan_q.size() == 2) begin
      checkOutput("post_rst_first", last_chan_q[0], 0);
      checkOutput("post_rst_second", last_chan_q[1], 3);
    end

    clearStats();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 9);
      applyStimulus(3, 9);
    end
    waitDone(100);
    checkOutput("rr_pkts", last_chan_q.size(), 6);
    for (int k = 0; k < 6 && k < last_chan_q.size(); k++) checkOutput("rr_order", last_chan_q[k], rr_exp[k]);
    checkOutput("rr_beats", out_beats, 12);
    checkOutput("rr_no_gap", last_out_cyc - first_out_cyc + 1, 12);

    for (int w = 0; w < 3; w++) d1[w] = {$urandom(), $urandom(), $urandom(), $urandom()};
    d1[0][31:16] = 16'd33;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      in1_valid = 1'b1; in1_data = d1[b];
      #1;
      guard = 0;
      while (!in1_ready && guard < 20) begin @(negedge clk); #1; guard++; end
      checkOutput("n1_ready", in1_ready, 1);
      @(negedge clk);
      in1_valid = 1'b0;
      #1;
      checkOutput("n1_valid", out1_valid, 1);
      checkOutput("n1_data", out1_data, d1[b]);
      checkOutput("n1_last", out1_last, (b == 2));
      checkOutput("n1_err", out1_err, 0);
      checkOutput("n1_chan", out1_chan, 0);
    end
    repeat (2) @(negedge clk);
    #1 checkOutput("n1_busy_end", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nukv_value_segmenter_mc.md
Name: nukv_value_segmenter_mc

Overview:
Multi-channel, parametrised value segmenter for the nukv value path. Arbitrates N_CHANNELS value streams at packet granularity, round-robin. Decodes the length header in each packet's first word and delimits the packet into DATA_WIDTH beats with last, channel id and error tags. Packets longer than MAX_BEATS are truncated and their remaining input beats are dropped. Sits between value readers and the response formatter.

Parameters:
DATA_WIDTH, 512, beat width in bits; power of two, at least 64
N_CHANNELS, 4, number of input value streams, at least 1
CHAN_W, 2, width of the channel id; at least clog2(N_CHANNELS), and 1 when N_CHANNELS=1
LEN_LSB, 0, bit position of the 16-bit length field in the first word
LEN_UNIT, 8, bytes per length unit; power of two
MAX_BEATS, 256, maximum beats emitted per packet; at least 1

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, asynchronous, active-low
in_data  in  N_CHANNELS*DATA_WIDTH  channel c occupies slice [c*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  N_CHANNELS  per-channel valid
in_ready  out  N_CHANNELS  per-channel ready
out_data  out  DATA_WIDTH  segment beat
out_valid  out  1  output valid
out_last  out  1  final beat of the packet
out_chan  out  CHAN_W  source channel of the beat
out_err  out  1  set on the last beat of a truncated packet
out_ready  in  1  downstream ready
busy  out  1  state is not IDLE, or the skid buffer is not empty

Behaviour:
- Reset asynchronous on rst_n low, released synchronously: state=IDLE, skid buffer empty, RR pointer=0, out_valid=0, out_last=0, out_err=0, out_chan=0, in_ready=0, busy=0.
- Beat count: bytes = len*LEN_UNIT, computed at 16+log2(LEN_UNIT) bits, no overflow. beats = ceil(bytes/(DATA_WIDTH/8)); len=0 gives 1 beat. Header word counts as beat 1. Computed with shift/add only; no divider.
- trunc = (beats > MAX_BEATS). emit = min(beats, MAX_BEATS).
- IDLE:
  - Pick the first valid channel at or after the RR pointer. Decision is combinational; in_ready of the winner rises in the same cycle.
  - On header handshake: latch len, grant, emit, remaining = beats - emit; RR pointer = grant+1 mod N_CHANNELS.
  - Go to PASS if emit>1. If emit==1: go to DRAIN if remaining>0, else stay in IDLE (next packet may start the next cycle).
- PASS: forward beats of the granted channel. On the beat numbered emit: out_last=1, out_err=trunc; go to DRAIN if remaining>0, else IDLE.
- DRAIN: in_ready[grant]=1 regardless of the skid buffer. Consume remaining beats with no output, decrementing the counter; go to IDLE after the final one.
- in_ready:
  - Only the granted channel (or the IDLE winner) is ever ready.
  - In IDLE/PASS it also requires a free skid slot.
  - Never combinationally dependent on out_ready.
- Output path:
  - 2-entry skid FIFO holding {err, last, chan, data}; out_* driven from its head.
  - Latency from input handshake to out_valid is 1 cycle.
  - Full throughput of 1 beat/clk under sustained out_ready.
  - Simultaneous push and pop at count 2 is disallowed, since in_ready was low.
  - Once out_valid rises, out_* stays stable until out_ready.
- Packets never interleave: a new grant happens only in IDLE.
- A channel whose in_valid drops mid-packet stalls the block; no timeout.
- Reset mid-packet: all state lost, in-flight beats discarded, outputs at reset values immediately.
- busy=1 whenever state!=IDLE or the skid buffer is not empty.

Test Plan:
Unless noted: DATA_WIDTH=512, LEN_UNIT=8, MAX_BEATS=16, N_CHANNELS=4, LEN_LSB=0.
- ch0 header len=8 (64 B), out_ready=1 -> 1 beat with last=1, err=0, chan=0, emitted the cycle after the handshake; len=0 -> same single last beat; len=9 -> 2 beats, last only on beat 2; len=128 -> 16 beats, err=0.
- ch2 len=200 (1600 B, 25 beats) -> 16 output beats, beat 16 has last=1, err=1; the next 9 input beats are accepted with no output; busy drops after beat 25.
- ch0 and ch3 each hold 3 back-to-back 2-beat packets -> output order ch0,ch3,ch0,ch3,ch0,ch3; no interleave; zero idle cycles between packets.
- len=40 (5 beats) with out_ready toggling 1010... and random stalls -> data matches the input exactly, out_* held stable while stalled, in_ready low whenever the skid buffer holds 2 entries.
- rst_n pulsed low during beat 3 of a 10-beat packet -> out_valid=0 and in_ready=0 asynchronously; the next packet after release starts from the RR pointer at channel 0.
- N_CHANNELS=1, CHAN_W=1, DATA_WIDTH=128, LEN_UNIT=1, LEN_LSB=16, len=33 -> 3 beats, last on beat 3, err=0, chan=0.
